// File: rtl/stream_pipe.sv
// rtl/stream_pipe.sv - multi-lane valid/ready retiming pipeline with mask, flush, occupancy and beat counter
module stream_pipe #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 1,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          flush_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [CHANNELS*WIDTH-1:0]     data_i,
  input  logic [CHANNELS-1:0]           channel_mask_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [CHANNELS*WIDTH-1:0]     data_o,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy_o,
  output logic [CNT_WIDTH-1:0]          count_o,
  output logic                          overflow_o
);

  localparam int DW    = CHANNELS * WIDTH;
  localparam int OCC_W = $clog2(DEPTH + 1);

  if (WIDTH < 1 || CHANNELS < 1 || DEPTH < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("stream_pipe: WIDTH, CHANNELS, DEPTH and CNT_WIDTH must all be >= 1");
  end

  logic [DEPTH-1:0] valid_q;
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DW-1:0]    cap_data;
  logic             accept;
  logic             deliver;
  logic             full_above;
  logic [OCC_W-1:0] occ_d;

  // A stage may load when downstream accepts or any stage at or after it is
  // empty; written flat per stage rather than as a self-referencing chain.
  always_comb begin
    load       = '0;
    full_above = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      full_above = 1'b1;
      for (int j = k; j < DEPTH; j++) begin
        full_above = full_above & valid_q[j];
      end
      load[k] = ready_i | ~full_above;
    end
  end

  assign ready_o = enable_i & load[0] & ~flush_i & rst_i;
  assign accept  = valid_i & ready_o;

  always_comb begin
    cap_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cap_data[c*WIDTH +: WIDTH] = channel_mask_i[c] ? '0 : data_i[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      if (load[0]) begin
        valid_q[0] <= accept;
        if (accept) begin
          data_q[0] <= cap_data;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            data_q[k] <= data_q[k-1];
          end
        end
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];
  assign deliver = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else if (deliver) begin
      count_o <= count_o + CNT_WIDTH'(1);
      if (&count_o) begin
        overflow_o <= 1'b1;
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(valid_q[k]);
    end
  end

  assign occupancy_o = occ_d;

endmodule

// File: doc/stream_pipe.md
Name: stream_pipe

Overview:
- Parametrised successor to the single-register, enable-gated datapath stage.
- Generalised to CHANNELS lanes of WIDTH bits and DEPTH pipeline stages, with valid/ready handshakes on both sides.
- Adds per-channel masking, flush, occupancy reporting and a delivered-beat counter with sticky wrap flag.
- Sits between a producer and consumer on any streaming datapath, as a retiming/buffer stage.

Parameters:
- WIDTH, 8, bits per channel (>=1)
- CHANNELS, 1, number of parallel lanes sharing one handshake (>=1)
- DEPTH, 2, number of pipeline stages (>=1)
- CNT_WIDTH, 16, width of delivered-beat counter (>=1)

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  asynchronous, active-low reset
- enable_i  input  1  input acceptance enable
- flush_i  input  1  synchronous pipeline flush
- valid_i  input  1  upstream beat valid
- ready_o  output  1  stage accepts beat this cycle
- data_i  input  CHANNELS*WIDTH  upstream data, channel c at [c*WIDTH +: WIDTH]
- channel_mask_i  input  CHANNELS  1 = channel zeroed on capture
- valid_o  output  1  output stage holds a beat
- ready_i  input  1  downstream accepts beat
- data_o  output  CHANNELS*WIDTH  output stage data
- occupancy_o  output  $clog2(DEPTH+1)  number of valid stages
- count_o  output  CNT_WIDTH  beats delivered downstream
- overflow_o  output  1  sticky: count_o has wrapped

Behaviour:
- State: valid_q[k] and data_q[k] for k = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives valid_o/data_o.
- Reset (rst_i low, async):
  - all valid_q, data_q, count_o and overflow_o go to 0;
  - valid_o=0, data_o=0, occupancy_o=0;
  - ready_o forced 0 while rst_i low.
- Load rules:
  - load[DEPTH-1] = ~valid_q[DEPTH-1] | ready_i.
  - load[k] = ~valid_q[k] | load[k+1] for k < DEPTH-1.
  - Combinational chain, so a full pipe with ready_i=1 sustains one beat per cycle with no bubbles.
- ready_o = enable_i & load[0] & ~flush_i & rst_i. Input accepted when valid_i & ready_o.
- enable_i low blocks input only; stored beats continue to drain downstream.
- Stage k>0 on load[k]: takes valid_q[k-1] and data_q[k-1]. Data is captured only when the incoming valid is 1; otherwise data is held.
- Stage 0 on load[0]: valid_q[0] <= valid_i & ready_o, and data captured on acceptance.
- Masking: channel c stored as all-zero if channel_mask_i[c]=1. The mask is sampled in the acceptance cycle only; later mask changes do not alter stored beats.
- Latency: beat accepted in cycle n appears on valid_o/data_o in cycle n+DEPTH when no stalls occur.
- Output rules: valid_o never drops and data_o never changes while valid_o=1 and ready_i=0.
- flush_i=1 (synchronous):
  - input not accepted;
  - the output handshake in the same cycle still counts if valid_o & ready_i;
  - next cycle all valid_q=0; data_q is not cleared.
  - Flush has priority over all stage loads.
- count_o increments by 1 on each valid_o & ready_i.
  - Wraps from 2^CNT_WIDTH-1 to 0, and overflow_o sets to 1 on that wrap.
  - overflow_o clears only on reset; the flush and enable_i inputs do not affect count_o or overflow_o.
- occupancy_o = popcount(valid_q), registered-state derived, range 0..DEPTH.
- Reset asserted mid-stream drops all in-flight beats immediately.
- Illegal parameter values (any <1) cause an elaboration-time error.

Test Plan:
- Latency: DEPTH=2, CHANNELS=1, WIDTH=8, ready_i=1, send 0x11,0x22,0x33 back-to-back -> valid_o high cycles 2,3,4 with 0x11,0x22,0x33; count_o=3; ready_o constant 1.
- Backpressure: DEPTH=3, hold ready_i=0, stream 5 beats -> ready_o drops after 3 accepted; occupancy_o=3; data_o stable. Then release ready_i -> all 5 delivered in order with no loss or duplication.
- Masking: CHANNELS=4, WIDTH=8, data_i=0xDDCCBBAA, mask=4'b0101 -> data_o=0xDD00BB00. Mask change after capture has no effect.
- Flush: pipe full (DEPTH=2), ready_i=1, pulse flush_i one cycle -> that cycle's output beat counted (count +1); next cycle valid_o=0, occupancy_o=0; ready_o=0 during the flush cycle.
- Enable and wrap: CNT_WIDTH=2, enable_i=0 with valid_i=1 -> ready_o=0 and nothing accepted. With enable_i=1, deliver 5 beats -> count_o sequence 1,2,3,0,1; overflow_o=1 from the 4th beat and stays 1.
- Reset mid-operation: assert rst_i low asynchronously (between edges) with pipe full -> valid_o, occupancy_o, count_o, overflow_o go to 0 immediately. After release, the first new beat emerges after DEPTH cycles.
